// File: rtl/adder16_seq_if.sv
// Request, response and adder-slice signals of the wide add/subtract sequencer.
// slave = sequencer side, master = issue logic / consumer / adder side.
interface adder16_seq_if #(
  parameter int unsigned WORDS = 2
);
  localparam int unsigned W = 16 * WORDS;

  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic [4:0]   rsp_flags;

  logic [15:0]  add_a;
  logic [15:0]  add_b;
  logic         add_c0;
  logic [15:0]  add_sum;
  logic         add_cf;
  logic         add_of;
  logic         add_sf;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    input  add_sum, add_cf, add_of, add_sf,
    output req_ready, rsp_valid, rsp_sum, rsp_flags,
    output add_a, add_b, add_c0
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    output add_sum, add_cf, add_of, add_sf,
    input  req_ready, rsp_valid, rsp_sum, rsp_flags,
    input  add_a, add_b, add_c0
  );
endinterface

// File: rtl/adder16_seq.sv
// Multi-cycle wide ADD/SUB/ADC/SBB sequencer driving a shared 16-bit adder slice, LSB chunk first.
// Define ADDER16_SEQ_CHAIN_EN to keep a saved carry across requests for ADC/SBB chaining.
module adder16_seq #(
  parameter int unsigned WORDS = 2
) (
  input logic          clk,
  input logic          rst_n,
  adder16_seq_if.slave bus
);
  localparam int unsigned W     = 16 * WORDS;
  localparam int unsigned IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned TOPSH = W - 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [IDXW-1:0] idx;
  logic [W-1:0]    a_rest;
  logic [W-1:0]    b_rest;
  logic            sub_q;
  logic            zf_acc;
  logic            pf_acc;

  logic            cin_c;
  logic            cf_fin_c;
  logic            zf_nxt_c;
  logic            pf_nxt_c;
  logic [W-1:0]    sum_nxt_c;

`ifdef ADDER16_SEQ_CHAIN_EN
  logic saved_cf;
  // ADC takes the saved carry, SBB the inverted saved borrow
  assign cin_c = bus.req_op[1] ? (saved_cf ^ bus.req_op[0]) : bus.req_op[0];
`else
  logic unused_op_hi;
  assign unused_op_hi = bus.req_op[1];
  assign cin_c        = bus.req_op[0];
`endif

  assign cf_fin_c  = bus.add_cf ^ sub_q;
  assign zf_nxt_c  = zf_acc & (bus.add_sum == 16'h0000);
  assign pf_nxt_c  = pf_acc ^ (^bus.add_sum);
  // Chunks enter at the top and shift down, so after WORDS steps the LSB chunk sits at bit 0
  assign sum_nxt_c = (bus.rsp_sum >> 16) | (W'(bus.add_sum) << TOPSH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      a_rest        <= '0;
      b_rest        <= '0;
      sub_q         <= 1'b0;
      zf_acc        <= 1'b1;
      pf_acc        <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_sum   <= '0;
      bus.rsp_flags <= 5'b00000;
      bus.add_a     <= 16'h0000;
      bus.add_b     <= 16'h0000;
      bus.add_c0    <= 1'b0;
`ifdef ADDER16_SEQ_CHAIN_EN
      saved_cf      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state         <= RUN;
            idx           <= '0;
            a_rest        <= bus.req_a >> 16;
            b_rest        <= bus.req_b >> 16;
            sub_q         <= bus.req_op[0];
            zf_acc        <= 1'b1;
            pf_acc        <= 1'b0;
            bus.req_ready <= 1'b0;
            bus.add_a     <= bus.req_a[15:0];
            bus.add_b     <= bus.req_b[15:0] ^ {16{bus.req_op[0]}};
            bus.add_c0    <= cin_c;
          end
        end
        RUN: begin
          bus.rsp_sum <= sum_nxt_c;
          zf_acc      <= zf_nxt_c;
          pf_acc      <= pf_nxt_c;
          idx         <= idx + IDXW'(1);
          if (idx == IDXW'(WORDS - 1)) begin
            state         <= DONE;
            idx           <= idx;
            bus.rsp_valid <= 1'b1;
            bus.rsp_flags <= {bus.add_sf, cf_fin_c, bus.add_of, pf_nxt_c, zf_nxt_c};
            bus.add_a     <= 16'h0000;
            bus.add_b     <= 16'h0000;
            bus.add_c0    <= 1'b0;
`ifdef ADDER16_SEQ_CHAIN_EN
            saved_cf      <= cf_fin_c;
`endif
          end else begin
            a_rest     <= a_rest >> 16;
            b_rest     <= b_rest >> 16;
            bus.add_a  <= a_rest[15:0];
            bus.add_b  <= b_rest[15:0] ^ {16{sub_q}};
            bus.add_c0 <= bus.add_cf;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder16_seq.sv
// Directed bench for adder16_seq (WORDS=2) with a behavioural 16-bit adder slice.
// Build with ADDER16_SEQ_CHAIN_EN defined to exercise the saved-carry expectations.
module tb_adder16_seq;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [16:0] s17;
  logic [15:0] obs_b   [8];
  logic        obs_c0  [8];
  logic        obs_rdy [8];

  adder16_seq_if #(.WORDS(2)) bus ();

  adder16_seq #(.WORDS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 16-bit slice: combinational sum and flags
  always_comb begin
    s17         = {1'b0, bus.add_a} + {1'b0, bus.add_b} + 17'(bus.add_c0);
    bus.add_sum = s17[15:0];
    bus.add_cf  = s17[16];
    bus.add_sf  = s17[15];
    bus.add_of  = (bus.add_a[15] == bus.add_b[15]) && (s17[15] != bus.add_a[15]);
  end

  // Issue one request from IDLE; returns at the negedge where rsp_valid is seen (or on timeout)
  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      if (lat < 8) begin
        obs_b[lat]   = bus.add_b;
        obs_c0[lat]  = bus.add_c0;
        obs_rdy[lat] = bus.req_ready;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset req_ready: got %b expected 1", bus.req_ready); end
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset rsp_valid: got %b expected 0", bus.rsp_valid); end
    n_vec++; if (bus.rsp_sum !== 32'h0) begin n_err++; $display("FAIL reset rsp_sum: got %h expected 0", bus.rsp_sum); end
    n_vec++; if (bus.rsp_flags !== 5'b0) begin n_err++; $display("FAIL reset rsp_flags: got %b expected 00000", bus.rsp_flags); end
    n_vec++; if ({bus.add_a, bus.add_b, bus.add_c0} !== 33'h0) begin n_err++; $display("FAIL reset adder ports: got %h %h %b expected 0", bus.add_a, bus.add_b, bus.add_c0); end
  endtask

  task automatic test_add_carry();
    int lat;
    do_req(OP_ADD, 32'h0000FFFF, 32'h00000001, lat);
    n_vec++; if (lat != 2) begin n_err++; $display("FAIL add_carry latency: got %0d expected 2", lat); end
    n_vec++; if (bus.rsp_sum !== 32'h00010000) begin n_err++; $display("FAIL add_carry sum: got %h expected 00010000", bus.rsp_sum); end
    n_vec++; if (bus.rsp_flags !== 5'b00010) begin n_err++; $display("FAIL add_carry flags: got %b expected 00010", bus.rsp_flags); end
    n_vec++; if (obs_c0[0] !== 1'b0) begin n_err++; $display("FAIL add_carry c0 low: got %b expected 0", obs_c0[0]); end
    n_vec++; if (obs_c0[1] !== 1'b1) begin n_err++; $display("FAIL add_carry c0 high: got %b expected 1", obs_c0[1]); end
    n_vec++; if (obs_rdy[0] !== 1'b0) begin n_err++; $display("FAIL add_carry req_ready in RUN: got %b expected 0", obs_rdy[0]); end
    n_vec++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL add_carry req_ready in DONE: got %b expected 0", bus.req_ready); end
    release_rsp();
    n_vec++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_carry back to idle: got rdy=%b vld=%b expected 1 0", bus.req_ready, bus.rsp_valid); end
  endtask

  task automatic test_sub_borrow();
    int lat;
    do_req(OP_SUB, 32'h00000000, 32'h00000001, lat);
    n_vec++; if (lat != 2) begin n_err++; $display("FAIL sub latency: got %0d expected 2", lat); end
    n_vec++; if (bus.rsp_sum !== 32'hFFFFFFFF) begin n_err++; $display("FAIL sub sum: got %h expected ffffffff", bus.rsp_sum); end
    n_vec++; if (bus.rsp_flags !== 5'b11000) begin n_err++; $display("FAIL sub flags: got %b expected 11000", bus.rsp_flags); end
    n_vec++; if (obs_b[0] !== 16'hFFFE) begin n_err++; $display("FAIL sub add_b low: got %h expected fffe", obs_b[0]); end
    n_vec++; if (obs_b[1] !== 16'hFFFF) begin n_err++; $display("FAIL sub add_b high: got %h expected ffff", obs_b[1]); end
    n_vec++; if (obs_c0[0] !== 1'b1) begin n_err++; $display("FAIL sub c0 low: got %b expected 1", obs_c0[0]); end
    release_rsp();
  endtask

  task automatic test_overflow();
    int lat;
    do_req(OP_ADD, 32'h7FFFFFFF, 32'h00000001, lat);
    n_vec++; if (bus.rsp_sum !== 32'h80000000) begin n_err++; $display("FAIL ovf sum: got %h expected 80000000", bus.rsp_sum); end
    n_vec++; if (bus.rsp_flags !== 5'b10110) begin n_err++; $display("FAIL ovf flags: got %b expected 10110", bus.rsp_flags); end
    release_rsp();
  endtask

  task automatic test_adc_chain();
    int lat;
    do_req(OP_ADD, 32'hFFFFFFFF, 32'h00000001, lat);
    n_vec++; if (bus.rsp_sum !== 32'h0) begin n_err++; $display("FAIL wrap sum: got %h expected 00000000", bus.rsp_sum); end
    n_vec++; if (bus.rsp_flags !== 5'b01001) begin n_err++; $display("FAIL wrap flags: got %b expected 01001", bus.rsp_flags); end
    release_rsp();
    do_req(OP_ADC, 32'h0, 32'h0, lat);
`ifdef ADDER16_SEQ_CHAIN_EN
    n_vec++; if (bus.rsp_sum !== 32'h00000001) begin n_err++; $display("FAIL adc sum: got %h expected 00000001", bus.rsp_sum); end
    n_vec++; if (bus.rsp_flags !== 5'b00010) begin n_err++; $display("FAIL adc flags: got %b expected 00010", bus.rsp_flags); end
`else
    n_vec++; if (bus.rsp_sum !== 32'h00000000) begin n_err++; $display("FAIL adc sum: got %h expected 00000000", bus.rsp_sum); end
    n_vec++; if (bus.rsp_flags !== 5'b00001) begin n_err++; $display("FAIL adc flags: got %b expected 00001", bus.rsp_flags); end
`endif
    release_rsp();
  endtask

  task automatic test_sbb_chain();
    int lat;
    do_req(OP_SUB, 32'h0, 32'h1, lat);
    release_rsp();
    do_req(OP_SBB, 32'h00000005, 32'h00000002, lat);
`ifdef ADDER16_SEQ_CHAIN_EN
    n_vec++; if (bus.rsp_sum !== 32'h00000002) begin n_err++; $display("FAIL sbb sum: got %h expected 00000002", bus.rsp_sum); end
    n_vec++; if (bus.rsp_flags !== 5'b00010) begin n_err++; $display("FAIL sbb flags: got %b expected 00010", bus.rsp_flags); end
`else
    n_vec++; if (bus.rsp_sum !== 32'h00000003) begin n_err++; $display("FAIL sbb sum: got %h expected 00000003", bus.rsp_sum); end
    n_vec++; if (bus.rsp_flags !== 5'b00000) begin n_err++; $display("FAIL sbb flags: got %b expected 00000", bus.rsp_flags); end
`endif
    release_rsp();
  endtask

  task automatic test_backpressure();
    int lat;
    do_req(OP_ADD, 32'h12345678, 32'h11111111, lat);
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = (i % 2 == 0);
      bus.req_a     = 32'hDEAD0000 + 32'(i);
      @(posedge clk);
      @(negedge clk);
      n_vec++; if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin n_err++; $display("FAIL bp[%0d] handshake: got vld=%b rdy=%b expected 1 0", i, bus.rsp_valid, bus.req_ready); end
      n_vec++; if (bus.rsp_sum !== 32'h23456789) begin n_err++; $display("FAIL bp[%0d] sum: got %h expected 23456789", i, bus.rsp_sum); end
      n_vec++; if (bus.rsp_flags !== 5'b00000) begin n_err++; $display("FAIL bp[%0d] flags: got %b expected 00000", i, bus.rsp_flags); end
    end
    // Response handshake and a new request presented on the same edge
    bus.req_valid = 1'b1;
    bus.req_op    = OP_ADD;
    bus.req_a     = 32'h00000003;
    bus.req_b     = 32'h00000004;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    n_vec++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_err++; $display("FAIL bp release: got vld=%b rdy=%b expected 0 1", bus.rsp_valid, bus.req_ready); end
    n_vec++; if (bus.rsp_sum !== 32'h23456789) begin n_err++; $display("FAIL bp idle hold sum: got %h expected 23456789", bus.rsp_sum); end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_vec++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL bp late accept: got rdy=%b expected 0", bus.req_ready); end
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    n_vec++; if (lat != 2) begin n_err++; $display("FAIL bp late latency: got %0d expected 2", lat); end
    n_vec++; if (bus.rsp_sum !== 32'h00000007 || bus.rsp_flags !== 5'b00010) begin n_err++; $display("FAIL bp late result: got %h/%b expected 00000007/00010", bus.rsp_sum, bus.rsp_flags); end
    release_rsp();
  endtask

  task automatic test_reset_mid_op();
    int   lat;
    logic saw_valid;
    do_req(OP_ADD, 32'hFFFFFFFF, 32'h00000001, lat);
    release_rsp();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_ADD;
    bus.req_a     = 32'h00050005;
    bus.req_b     = 32'h00000001;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n         = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid reset handshake: got rdy=%b vld=%b expected 1 0", bus.req_ready, bus.rsp_valid); end
    n_vec++; if (bus.rsp_flags !== 5'b0 || bus.rsp_sum !== 32'h0) begin n_err++; $display("FAIL mid reset result: got %h/%b expected 0/00000", bus.rsp_sum, bus.rsp_flags); end
    n_vec++; if ({bus.add_a, bus.add_b, bus.add_c0} !== 33'h0) begin n_err++; $display("FAIL mid reset adder ports: got %h %h %b expected 0", bus.add_a, bus.add_b, bus.add_c0); end
    saw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      saw_valid = saw_valid | bus.rsp_valid;
    end
    n_vec++; if (saw_valid !== 1'b0) begin n_err++; $display("FAIL mid reset stray response: got %b expected 0", saw_valid); end
    do_req(OP_ADC, 32'h00000001, 32'h00000001, lat);
    n_vec++; if (lat != 2) begin n_err++; $display("FAIL post reset latency: got %0d expected 2", lat); end
    n_vec++; if (bus.rsp_sum !== 32'h00000002 || bus.rsp_flags !== 5'b00010) begin n_err++; $display("FAIL post reset adc: got %h/%b expected 00000002/00010", bus.rsp_sum, bus.rsp_flags); end
    release_rsp();
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_a     = 32'h0;
    bus.req_b     = 32'h0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_add_carry();
    test_sub_borrow();
    test_overflow();
    test_adc_chain();
    test_sbb_chain();
    test_backpressure();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
